// File: rtl/mux_pkg.sv
// Shared constants and the data-word type for the 2:1 word multiplexer.
package mux_pkg;

  localparam int MUX_DEFAULT_WIDTH = 16;
  localparam logic [MUX_DEFAULT_WIDTH-1:0] MUX_DEFAULT_RESET_VALUE = 16'h0000;

  typedef logic [MUX_DEFAULT_WIDTH-1:0] data_word_t;

endpackage

// File: rtl/multiplexer_2_to_1_16_bit_if.sv
// Bus bundle for the 2:1 word multiplexer: select/data/enable in, combinational and registered results out.
// Parity outputs appear only when MUX_PARITY_EN is defined.
interface multiplexer_2_to_1_16_bit_if
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
);

  logic             S;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I0;
  logic             en;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_q;
  logic             Y_q_valid;
  logic             sel_q;
`ifdef MUX_PARITY_EN
  logic             Y_par;
  logic             Y_q_par;
`endif

  modport master (
    output S, I1, I0, en,
    input  Y, Y_q, Y_q_valid, sel_q
`ifdef MUX_PARITY_EN
    , input Y_par, Y_q_par
`endif
  );

  modport slave (
    input  S, I1, I0, en,
    output Y, Y_q, Y_q_valid, sel_q
`ifdef MUX_PARITY_EN
    , output Y_par, Y_q_par
`endif
  );

endinterface

// File: rtl/mux2_core.sv
// Purely combinational WIDTH-bit 2:1 select: Y = S ? I1 : I0.
module mux2_core #(
  parameter int WIDTH = 16
) (
  input  logic             S,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I0,
  output logic [WIDTH-1:0] Y
);

  // Per-bit conditional keeps X-select semantics: agreeing bits pass, differing bits go X.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign Y[gi] = S ? I1[gi] : I0[gi];
  end

endmodule

// File: rtl/multiplexer_2_to_1_16_bit.sv
// 2:1 word multiplexer with zero-latency output plus an enable-loaded registered copy.
// Define MUX_PARITY_EN to add combinational and registered parity outputs.
module multiplexer_2_to_1_16_bit
  import mux_pkg::*;
#(
  parameter int               WIDTH       = MUX_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = MUX_DEFAULT_RESET_VALUE
) (
  input logic                          clk,
  input logic                          rst_n,
  multiplexer_2_to_1_16_bit_if.slave   bus
);

  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] y_q_reg;
  logic             sel_q_reg;
  logic             valid_reg;

  mux2_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .S  (bus.S),
    .I1 (bus.I1),
    .I0 (bus.I0),
    .Y  (y_comb)
  );

  assign bus.Y = y_comb;

  // Reset dominates any concurrent load; valid is sticky until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_reg   <= RESET_VALUE;
      sel_q_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else if (bus.en) begin
      y_q_reg   <= y_comb;
      sel_q_reg <= bus.S;
      valid_reg <= 1'b1;
    end
  end

  assign bus.Y_q       = y_q_reg;
  assign bus.sel_q     = sel_q_reg;
  assign bus.Y_q_valid = valid_reg;

`ifdef MUX_PARITY_EN
  logic y_q_par_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_par_reg <= ^RESET_VALUE;
    end else if (bus.en) begin
      y_q_par_reg <= ^y_comb;
    end
  end

  assign bus.Y_par   = ^y_comb;
  assign bus.Y_q_par = y_q_par_reg;
`endif

endmodule

// File: tb/tb_multiplexer_2_to_1_16_bit.sv
// Directed bench for multiplexer_2_to_1_16_bit; covers parity outputs when MUX_PARITY_EN is defined.
module tb_multiplexer_2_to_1_16_bit;
  import mux_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  data_word_t sw_i1 [4] = '{16'h0056, 16'h009A, 16'h00DE, 16'h0000};
  data_word_t sw_i0 [4] = '{16'h0078, 16'h00BC, 16'h00F0, 16'hFFFF};

  multiplexer_2_to_1_16_bit_if #(.WIDTH(MUX_DEFAULT_WIDTH)) bus ();

  multiplexer_2_to_1_16_bit #(
    .WIDTH       (MUX_DEFAULT_WIDTH),
    .RESET_VALUE (MUX_DEFAULT_RESET_VALUE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    bus.S  = 1'b0;
    bus.I1 = '0;
    bus.I0 = '0;
    bus.en = 1'b0;

    // Asynchronous reset: outputs clear between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("rst_y_q", bus.Y_q, 32'h0000);
    check("rst_valid", bus.Y_q_valid, 32'h0);
    check("rst_sel_q", bus.sel_q, 32'h0);

    // Test 1: combinational select, reset held (no effect on Y)
    bus.I1 = 16'h0012; bus.I0 = 16'h0034; bus.S = 1'b0;
    #1 check("t1_s0", bus.Y, 32'h0034);
    bus.S = 1'b1;
    #1 check("t1_s1", bus.Y, 32'h0012);

    // Test 2: sweep including full-width 0000/FFFF
    for (int i = 0; i < 4; i++) begin
      bus.I1 = sw_i1[i]; bus.I0 = sw_i0[i]; bus.S = 1'b0;
      #1 check("t2_s0", bus.Y, {16'h0, sw_i0[i]});
      bus.S = 1'b1;
      #1 check("t2_s1", bus.Y, {16'h0, sw_i1[i]});
    end
    bus.S = 1'b0;
    #1 check("t2_ffff_again", bus.Y, 32'hFFFF);

    // Release reset; with en=0 the edge must not set valid
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t3_pre_y_q", bus.Y_q, 32'h0000);
    check("t3_pre_valid", bus.Y_q_valid, 32'h0);

    // Test 3: single load
    @(negedge clk);
    bus.S = 1'b1; bus.I1 = 16'hABCD; bus.en = 1'b1;
    #1 check("t3_before_edge", bus.Y_q, 32'h0000);
    @(posedge clk); #1;
    bus.en = 1'b0; bus.S = 1'b0; bus.I0 = 16'h1234;
    check("t3_y_q", bus.Y_q, 32'hABCD);
    check("t3_sel_q", bus.sel_q, 32'h1);
    check("t3_valid", bus.Y_q_valid, 32'h1);

    // Test 4: hold across three edges
    repeat (3) @(posedge clk);
    #1;
    check("t4_y_q_hold", bus.Y_q, 32'hABCD);
    check("t4_sel_hold", bus.sel_q, 32'h1);
    check("t4_valid_hold", bus.Y_q_valid, 32'h1);
    check("t4_y", bus.Y, 32'h1234);

    // Test 5: load with S=0, then reset mid-cycle
    @(negedge clk);
    bus.en = 1'b1; bus.I0 = 16'h5A5A; bus.I1 = 16'hC3C3; bus.S = 1'b0;
    @(posedge clk); #1;
    check("t5_load", bus.Y_q, 32'h5A5A);
    check("t5_sel0", bus.sel_q, 32'h0);
    bus.I0 = 16'h0F0F;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_y_q", bus.Y_q, 32'h0000);
    check("t5_rst_valid", bus.Y_q_valid, 32'h0);
    check("t5_y_tracks", bus.Y, 32'h0F0F);
    bus.S = 1'b1;
    #1 check("t5_y_tracks_s1", bus.Y, 32'hC3C3);

    // Reset held across an enabled edge: load discarded
    @(posedge clk); #1;
    check("t5_rst_wins", bus.Y_q, 32'h0000);
    check("t5_rst_wins_sel", bus.sel_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_reload", bus.Y_q, 32'hC3C3);
    check("t5_reload_sel", bus.sel_q, 32'h1);
    check("t5_reload_valid", bus.Y_q_valid, 32'h1);

`ifdef MUX_PARITY_EN
    // Test 6: parity
    bus.en = 1'b0; bus.S = 1'b0; bus.I0 = 16'h0007;
    #1 check("t6_par_7", bus.Y_par, 32'h1);
    bus.I0 = 16'h0003;
    #1 check("t6_par_3", bus.Y_par, 32'h0);
    check("t6_q_par_c3c3", bus.Y_q_par, 32'h0);
    @(negedge clk);
    bus.I0 = 16'h0007; bus.en = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    check("t6_q_par_7", bus.Y_q_par, 32'h1);
    #2 rst_n = 1'b0;
    #1 check("t6_q_par_rst", bus.Y_q_par, 32'h0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplexer_2_to_1_16_bit.md
Name: multiplexer_2_to_1_16_bit

Overview:
- Selects one of two data words onto an output bus: Y = I1 when S=1, Y = I0 when S=0.
- Used in the single-cycle RISC datapath for operand, write-back and PC-source selection.
- The primary output Y is purely combinational with zero latency.
- A registered copy of the output, with a load enable and a valid flag, is also provided for pipelined or retimed users.

Parameters:
- WIDTH, 16: data width of I0, I1, Y and Y_q.
- RESET_VALUE, 16'h0000: value loaded into Y_q on reset.

Ports:
- clk  input  1  Rising-edge clock; used by the registered path only.
- rst_n  input  1  Asynchronous, active-low reset.
- S  input  1  Select: 1 picks I1, 0 picks I0.
- I1  input  WIDTH  Data input selected when S=1.
- I0  input  WIDTH  Data input selected when S=0.
- en  input  1  Load enable for the registered path.
- Y  output  WIDTH  Combinational mux result.
- Y_q  output  WIDTH  Registered mux result.
- Y_q_valid  output  1  High once Y_q has been loaded since the last reset.
- sel_q  output  1  Registered copy of S captured at the last load.

Behaviour:
- Y = S ? I1 : I0, bit-for-bit across all WIDTH bits.
  - No clock dependency; Y follows input changes within the same delta/propagation time.
  - Reset has no effect on Y.
  - If S is X/Z in simulation: each Y bit equals the common value where I0 and I1 agree, and is X where they differ (standard conditional-operator semantics).
- Reset (rst_n=0, asynchronous assert):
  - Y_q = RESET_VALUE, Y_q_valid = 0, sel_q = 0, immediately, without waiting for a clock edge.
  - Deassertion takes effect at the next rising clk edge.
  - The system synchronises release externally.
- Rising clk edge with rst_n=1 and en=1:
  - Y_q <= Y, using the values present before the edge.
  - sel_q <= S.
  - Y_q_valid <= 1.
  - Latency from inputs to Y_q is exactly one cycle.
- Rising clk edge with en=0: Y_q, sel_q and Y_q_valid hold their values.
- Y_q_valid stays 1 until the next reset; it is never cleared by en=0.
- Reset asserted mid-operation, including in the same cycle as en=1: reset wins and the load is discarded.
- No arithmetic, no width conversion. Inputs and output are the same WIDTH; no sign or zero extension.

Optional Feature:
- Macro MUX_PARITY_EN.
- When defined:
  - Adds output Y_par (1 bit, combinational) = XOR-reduction of Y.
  - Adds output Y_q_par (1 bit, registered) = XOR-reduction of Y_q.
  - Y_q_par resets to the parity of RESET_VALUE and loads under the same en rule as Y_q.
- When not defined: neither port exists; all other behaviour is unchanged.

Decomposition:
- Package mux_pkg holds:
  - the default data width constant (16);
  - the default reset-value constant (16'h0000);
  - a typedef for the WIDTH-bit data word.
- One natural sub-module, mux2_core: purely combinational WIDTH-bit 2:1 select (S, I1, I0 -> Y).
  - The top instantiates mux2_core and adds the register stage and the optional parity logic.

Test Plan:
1. Combinational select, S=0: I1=16'h0012, I0=16'h0034 -> Y=16'h0034. Then S=1, same data -> Y=16'h0012 with no clock edge needed.
2. Combinational sweep: (I1,I0) = (16'h0056,16'h0078), (16'h009A,16'h00BC), (16'h00DE,16'h00F0), each with S=0 then S=1.
   - Expect Y = 16'h0078 / 16'h0056, 16'h00BC / 16'h009A, 16'h00F0 / 16'h00DE.
   - Also I0=16'hFFFF, I1=16'h0000 toggling S -> Y alternates 16'hFFFF / 16'h0000, proving full-width coverage.
3. Registered path: rst_n pulsed low then high; S=1, I1=16'hABCD, en=1 for one edge -> after the edge Y_q=16'hABCD, sel_q=1, Y_q_valid=1. Before that edge, Y_q=16'h0000 and Y_q_valid=0.
4. Enable hold: after test 3, set en=0, S=0, I0=16'h1234 across 3 edges -> Y_q stays 16'hABCD while Y=16'h1234.
5. Async reset mid-operation: en=1, inputs changing, rst_n dropped between clock edges -> Y_q=16'h0000, Y_q_valid=0, sel_q=0 immediately. Y keeps tracking the inputs.
6. With MUX_PARITY_EN defined: Y=16'h0007 -> Y_par=1; Y=16'h0003 -> Y_par=0. Y_q_par matches the parity of Y_q one cycle after a load.
